// File: rtl/apb_accum_pkg.sv
// apb_accum_pkg: shared definitions for the XOR-accumulator APB sequencer.
//   - Slave register addresses (ADDR_*)
//   - Control register codes (CTRL_*)
//   - Job state machine encoding (seq_state_t)
//   - APB transfer engine phase encoding (xfer_state_t)
package apb_accum_pkg;

  localparam logic [31:0] ADDR_VAL  = 32'h0000_0000;
  localparam logic [31:0] ADDR_MASK = 32'h0000_0004;
  localparam logic [31:0] ADDR_CTRL = 32'h0000_0008;
  localparam logic [31:0] ADDR_RES  = 32'h0000_000C;

  localparam logic [31:0] CTRL_ACC  = 32'h0000_0001;
  localparam logic [31:0] CTRL_CLR  = 32'h0000_0002;
  localparam logic [31:0] CTRL_INIT = 32'h0000_0003;

  // ST_BOOT is held during reset so job_ready stays low until the first
  // edge after PRESETn is released.
  typedef enum logic [3:0] {
    ST_BOOT,
    ST_IDLE,
    ST_MASK,
    ST_CLR,
    ST_WAIT_OP,
    ST_WR_VAL,
    ST_WR_CTRL,
    ST_RD_RES,
    ST_DRAIN,
    ST_DONE
  } seq_state_t;

  typedef enum logic [1:0] {
    XF_IDLE,
    XF_SETUP,
    XF_ACCESS
  } xfer_state_t;

endpackage

// File: rtl/apb_xfer_engine.sv
// apb_xfer_engine: performs one APB transfer per accepted request.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req, addr, wr, wdata       transfer request; accepted when idle or in the
//                              completing ACCESS cycle (back-to-back)
//   done                       one-cycle pulse in the completing/aborting cycle
//   rdata, slverr, timeout     response qualified by done
//   paddr..pwdata              APB request outputs
//   prdata, pready, pslverr    APB response inputs
module apb_xfer_engine
  import apb_accum_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic        wr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        slverr,
  output logic        timeout,
  output logic [31:0] paddr,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  xfer_state_t   state_reg, state_next;
  logic [TW-1:0] tcnt_reg, tcnt_next;
  logic [31:0]   paddr_reg, pwdata_reg;
  logic          pwrite_reg;
  logic          accept;

  // A new command can start in the same cycle the previous one completes,
  // which gives back-to-back SETUP phases without an idle cycle.
  assign accept = req && ((state_reg == XF_IDLE) ||
                          ((state_reg == XF_ACCESS) && pready));

  always_comb begin
    state_next = state_reg;
    tcnt_next  = tcnt_reg;
    done       = 1'b0;
    slverr     = 1'b0;
    timeout    = 1'b0;
    case (state_reg)
      XF_IDLE: begin
        if (accept) state_next = XF_SETUP;
      end
      XF_SETUP: begin
        state_next = XF_ACCESS;
        tcnt_next  = '0;
      end
      XF_ACCESS: begin
        if (pready) begin
          done       = 1'b1;
          slverr     = pslverr;
          state_next = accept ? XF_SETUP : XF_IDLE;
        end else if (tcnt_reg == T_LAST) begin
          // Last permitted wait cycle: abort, bus goes idle next cycle.
          done       = 1'b1;
          timeout    = 1'b1;
          state_next = XF_IDLE;
        end else begin
          tcnt_next = tcnt_reg + TW'(1);
        end
      end
      default: state_next = XF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= XF_IDLE;
      tcnt_reg   <= '0;
      paddr_reg  <= '0;
      pwdata_reg <= '0;
      pwrite_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      tcnt_reg  <= tcnt_next;
      if (accept) begin
        paddr_reg  <= addr;
        pwdata_reg <= wdata;
        pwrite_reg <= wr;
      end
    end
  end

  assign psel    = (state_reg != XF_IDLE);
  assign penable = (state_reg == XF_ACCESS);
  assign paddr   = paddr_reg;
  assign pwdata  = pwdata_reg;
  assign pwrite  = pwrite_reg;
  assign rdata   = prdata;

endmodule

// File: rtl/apb_accum_seq.sv
// apb_accum_seq: APB master sequencer for the XOR-accumulator slave.
// Accepts a job (mask, init) and an operand stream, programs the slave
// (mask, clear or seed, one accumulate per operand), reads the result back
// and returns it with the operand count and error/timeout flags.
// Ports:
//   PCLK, PRESETn                       clock, synchronous active-low reset
//   job_valid/job_ready, job_mask/init  job handshake and parameters
//   op_valid/op_ready, op_data/op_last  operand stream
//   res_valid/res_ready, res_*          result handshake and payload
//   PADDR..PWDATA / PRDATA..PSLVERR     APB master bus
module apb_accum_seq
  import apb_accum_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 16
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [31:0]      job_mask,
  input  logic             job_init,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [31:0]      op_data,
  input  logic             op_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [CNT_W-1:0] res_count,
  output logic             res_err,
  output logic             res_timeout,
  output logic [31:0]      PADDR,
  output logic             PSEL,
  output logic             PENABLE,
  output logic             PWRITE,
  output logic [31:0]      PWDATA,
  input  logic [31:0]      PRDATA,
  input  logic             PREADY,
  input  logic             PSLVERR
);

  seq_state_t       state_reg, state_next;
  logic             init_reg, init_next;
  logic             last_reg, last_next;
  logic [CNT_W-1:0] count_reg, count_next, count_inc;
  logic [31:0]      res_data_reg, res_data_next;
  logic             err_reg, err_next;
  logic             tmo_reg, tmo_next;

  logic             xf_req, xf_wr, xf_done, xf_slverr, xf_timeout;
  logic [31:0]      xf_addr, xf_wdata, xf_rdata;
  logic             xf_ok, xf_abort;

  apb_xfer_engine #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_xfer (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .req     (xf_req),
    .addr    (xf_addr),
    .wr      (xf_wr),
    .wdata   (xf_wdata),
    .done    (xf_done),
    .rdata   (xf_rdata),
    .slverr  (xf_slverr),
    .timeout (xf_timeout),
    .paddr   (PADDR),
    .psel    (PSEL),
    .penable (PENABLE),
    .pwrite  (PWRITE),
    .pwdata  (PWDATA),
    .prdata  (PRDATA),
    .pready  (PREADY),
    .pslverr (PSLVERR)
  );

  assign count_inc = (count_reg == '1) ? count_reg : count_reg + CNT_W'(1);
  assign xf_ok     = xf_done && !xf_timeout;
  assign xf_abort  = xf_done && xf_timeout;

  // Transfer requests are issued on the transition into each transfer state
  // so the SETUP phase starts on the very next cycle; the engine latches the
  // command, so unlatched inputs (job_mask, op_data) can be used directly.
  always_comb begin
    state_next    = state_reg;
    init_next     = init_reg;
    last_next     = last_reg;
    count_next    = count_reg;
    res_data_next = res_data_reg;
    err_next      = err_reg;
    tmo_next      = tmo_reg;
    xf_req        = 1'b0;
    xf_addr       = ADDR_VAL;
    xf_wr         = 1'b1;
    xf_wdata      = '0;
    job_ready     = 1'b0;
    op_ready      = 1'b0;
    res_valid     = 1'b0;

    if (xf_done) err_next = err_reg | xf_slverr | xf_timeout;
    if (xf_abort) begin
      tmo_next      = 1'b1;
      res_data_next = '0;
      state_next    = last_reg ? ST_DONE : ST_DRAIN;
    end

    case (state_reg)
      ST_BOOT: state_next = ST_IDLE;
      ST_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          init_next     = job_init;
          last_next     = 1'b0;
          count_next    = '0;
          res_data_next = '0;
          err_next      = 1'b0;
          tmo_next      = 1'b0;
          state_next    = ST_MASK;
          xf_req        = 1'b1;
          xf_addr       = ADDR_MASK;
          xf_wdata      = job_mask;
        end
      end
      ST_MASK: begin
        if (xf_ok) begin
          if (!init_reg) begin
            state_next = ST_CLR;
            xf_req     = 1'b1;
            xf_addr    = ADDR_CTRL;
            xf_wdata   = CTRL_CLR;
          end else begin
            state_next = ST_WAIT_OP;
          end
        end
      end
      ST_CLR: begin
        if (xf_ok) state_next = ST_WAIT_OP;
      end
      ST_WAIT_OP: begin
        op_ready = 1'b1;
        if (op_valid) begin
          last_next  = op_last;
          count_next = count_inc;
          state_next = ST_WR_VAL;
          xf_req     = 1'b1;
          xf_addr    = ADDR_VAL;
          xf_wdata   = op_data;
        end
      end
      ST_WR_VAL: begin
        if (xf_ok) begin
          state_next = ST_WR_CTRL;
          xf_req     = 1'b1;
          xf_addr    = ADDR_CTRL;
          // Only the first operand of a seeded job loads add_value directly.
          xf_wdata   = (init_reg && (count_reg == CNT_W'(1))) ? CTRL_INIT : CTRL_ACC;
        end
      end
      ST_WR_CTRL: begin
        if (xf_ok) begin
          if (last_reg) begin
            state_next = ST_RD_RES;
            xf_req     = 1'b1;
            xf_addr    = ADDR_RES;
            xf_wr      = 1'b0;
          end else begin
            state_next = ST_WAIT_OP;
          end
        end
      end
      ST_RD_RES: begin
        if (xf_ok) begin
          res_data_next = xf_rdata;
          state_next    = ST_DONE;
        end
      end
      ST_DRAIN: begin
        // Remaining operands of an aborted job are swallowed but counted.
        op_ready = 1'b1;
        if (op_valid) begin
          count_next = count_inc;
          if (op_last) state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_reg    <= ST_BOOT;
      init_reg     <= 1'b0;
      last_reg     <= 1'b0;
      count_reg    <= '0;
      res_data_reg <= '0;
      err_reg      <= 1'b0;
      tmo_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      init_reg     <= init_next;
      last_reg     <= last_next;
      count_reg    <= count_next;
      res_data_reg <= res_data_next;
      err_reg      <= err_next;
      tmo_reg      <= tmo_next;
    end
  end

  assign res_data    = res_data_reg;
  assign res_count   = count_reg;
  assign res_err     = err_reg;
  assign res_timeout = tmo_reg;

endmodule

// File: tb/tb_apb_accum_seq.sv
// tb_apb_accum_seq: directed bench for apb_accum_seq with a behavioural
// XOR-accumulator slave (one wait state per transfer, optional PREADY stall
// and PSLVERR injection).
module tb_apb_accum_seq;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        job_valid, job_ready, job_init;
  logic [31:0] job_mask;
  logic        op_valid, op_ready, op_last;
  logic [31:0] op_data;
  logic        res_valid, res_ready, res_err, res_timeout;
  logic [31:0] res_data;
  logic [15:0] res_count;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

  always #5 PCLK = ~PCLK;

  apb_accum_seq #(.TIMEOUT_CYC(16), .CNT_W(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .job_valid(job_valid), .job_ready(job_ready), .job_mask(job_mask), .job_init(job_init),
    .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data), .op_last(op_last),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_count(res_count), .res_err(res_err), .res_timeout(res_timeout),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // ---------------- slave model ----------------
  logic [31:0] s_val, s_mask, s_res, err_addr;
  logic        acc_seen, stall_pready, err_en;
  logic [63:0] wr_log[$];

  assign PREADY  = PSEL && PENABLE && acc_seen && !stall_pready;
  assign PRDATA  = (PADDR == 32'hC) ? s_res : 32'h0;
  assign PSLVERR = PREADY && err_en && (PADDR == err_addr);

  always @(posedge PCLK) begin
    if (!PRESETn) begin
      acc_seen <= 1'b0;
      s_val    <= '0;
      s_mask   <= '0;
      s_res    <= '0;
    end else begin
      acc_seen <= PSEL && PENABLE && !PREADY;
      if (PSEL && PENABLE && PREADY && PWRITE) begin
        wr_log.push_back({PADDR, PWDATA});
        case (PADDR)
          32'h0: s_val <= PWDATA;
          32'h4: s_mask <= PWDATA;
          32'h8: begin
            case (PWDATA[1:0])
              2'b01: s_res <= s_res ^ (s_val & s_mask);
              2'b10: s_res <= '0;
              2'b11: s_res <= s_val;
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_job(input logic [31:0] m, input logic ini);
    int n;
    job_mask = m; job_init = ini; job_valid = 1'b1; n = 0;
    while (!job_ready && n < 300) begin @(negedge PCLK); n++; end
    chk("job_wait", 128'(n < 300), 128'(1));
    @(negedge PCLK);
    job_valid = 1'b0;
  endtask

  task automatic send_op(input logic [31:0] d, input logic last);
    int n;
    op_data = d; op_last = last; op_valid = 1'b1; n = 0;
    while (!op_ready && n < 300) begin @(negedge PCLK); n++; end
    chk("op_wait", 128'(n < 300), 128'(1));
    @(negedge PCLK);
    op_valid = 1'b0;
  endtask

  task automatic get_result(input string tag, input logic [31:0] d, input logic [15:0] c,
                            input logic e, input logic t);
    int n;
    res_ready = 1'b1; n = 0;
    while (!res_valid && n < 300) begin @(negedge PCLK); n++; end
    chk({tag, "_res_wait"}, 128'(n < 300), 128'(1));
    chk({tag, "_res"}, {res_data, res_count, res_err, res_timeout}, {d, c, e, t});
    $display("job %s: data=%08h count=%0d err=%b timeout=%b", tag, res_data, res_count,
             res_err, res_timeout);
    @(negedge PCLK);
    res_ready = 1'b0;
  endtask

  task automatic chk_writes(input string tag, input int base, input logic [63:0] e[$]);
    chk({tag, "_wr_count"}, 128'(wr_log.size() - base), 128'(e.size()));
    for (int i = 0; i < e.size(); i++) begin
      if (base + i < wr_log.size()) chk({tag, "_wr"}, 128'(wr_log[base + i]), 128'(e[i]));
    end
  endtask

  function automatic logic [119:0] all_outs();
    return {PSEL, PENABLE, PWRITE, PADDR, PWDATA, job_ready, op_ready, res_valid,
            res_data, res_count, res_err, res_timeout};
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int base, n;
    logic stable;
    logic [63:0] e[$];
    job_valid = 0; job_mask = 0; job_init = 0;
    op_valid = 0; op_data = 0; op_last = 0; res_ready = 0;
    stall_pready = 0; err_en = 0; err_addr = 0;

    // Reset state
    repeat (3) @(negedge PCLK);
    chk("reset_outputs", 128'(all_outs()), 128'(0));
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("job_ready_after_reset", 128'(job_ready), 128'(1));

    // Job 1: clear then three accumulates, full mask
    base = wr_log.size();
    send_job(32'hFFFF_FFFF, 1'b0);
    chk("t1_first_setup", {PSEL, PENABLE, PWRITE, PADDR}, {1'b1, 1'b0, 1'b1, 32'h4});
    send_op(32'h5, 1'b0);
    chk("t1_op_setup", {PSEL, PENABLE, PADDR, PWDATA}, {1'b1, 1'b0, 32'h0, 32'h5});
    send_op(32'h3, 1'b0);
    send_op(32'h8, 1'b1);
    n = 0;
    while (!(PSEL && PENABLE && PREADY && !PWRITE && PADDR == 32'hC) && n < 200) begin
      @(negedge PCLK); n++;
    end
    chk("t1_read_wait", 128'(n < 200), 128'(1));
    @(negedge PCLK);
    chk("t1_res_latency", 128'(res_valid), 128'(1));
    get_result("t1", 32'hE, 16'd3, 1'b0, 1'b0);
    e = '{{32'h4, 32'hFFFF_FFFF}, {32'h8, 32'h2}, {32'h0, 32'h5}, {32'h8, 32'h1},
          {32'h0, 32'h3}, {32'h8, 32'h1}, {32'h0, 32'h8}, {32'h8, 32'h1}};
    chk_writes("t1", base, e);

    // Job 2: seeded by first operand, mask applies only to later operands
    base = wr_log.size();
    send_job(32'h0F, 1'b1);
    send_op(32'h10, 1'b0);
    send_op(32'h01, 1'b1);
    get_result("t2", 32'h11, 16'd2, 1'b0, 1'b0);
    e = '{{32'h4, 32'h0F}, {32'h0, 32'h10}, {32'h8, 32'h3}, {32'h0, 32'h1}, {32'h8, 32'h1}};
    chk_writes("t2", base, e);

    // Job 3: PREADY stalled on the second WR_VAL -> timeout and drain
    base = wr_log.size();
    send_job(32'hFFFF_FFFF, 1'b0);
    send_op(32'h1, 1'b0);
    send_op(32'h2, 1'b0);
    stall_pready = 1'b1;
    chk("t3_stalled_setup", {PSEL, PENABLE, PADDR, PWDATA}, {1'b1, 1'b0, 32'h0, 32'h2});
    n = 0;
    @(negedge PCLK);
    while (PSEL && PENABLE && n < 100) begin n++; @(negedge PCLK); end
    chk("t3_access_cycles", 128'(n), 128'(16));
    chk("t3_bus_idle", {PSEL, PENABLE}, {1'b0, 1'b0});
    stall_pready = 1'b0;
    send_op(32'h4, 1'b0);
    send_op(32'h8, 1'b1);
    get_result("t3", 32'h0, 16'd4, 1'b1, 1'b1);
    chk("t3_wr_count", 128'(wr_log.size() - base), 128'(4));

    // Job 4: PSLVERR on the mask write, sequence still completes
    err_en = 1'b1; err_addr = 32'h4;
    send_job(32'hFF, 1'b0);
    send_op(32'hF0, 1'b0);
    send_op(32'h0F, 1'b1);
    get_result("t4", 32'hFF, 16'd2, 1'b1, 1'b0);
    err_en = 1'b0;

    // Job 5: result held for 10 cycles without res_ready
    send_job(32'hFFFF_FFFF, 1'b0);
    send_op(32'h77, 1'b1);
    n = 0;
    while (!res_valid && n < 200) begin @(negedge PCLK); n++; end
    chk("t5_res_wait", 128'(n < 200), 128'(1));
    stable = 1'b1;
    repeat (10) begin
      @(negedge PCLK);
      if (!(res_valid === 1'b1 && res_data === 32'h77 && res_count === 16'd1 &&
            job_ready === 1'b0)) stable = 1'b0;
    end
    chk("t5_hold_stable", 128'(stable), 128'(1));
    $display("job t5: data=%08h count=%0d err=%b timeout=%b", res_data, res_count,
             res_err, res_timeout);
    job_mask = 32'hFFFF_FFFF; job_init = 1'b0; job_valid = 1'b1; res_ready = 1'b1;
    @(negedge PCLK);
    res_ready = 1'b0;
    chk("t5_next_job_ready", {res_valid, job_ready}, {1'b0, 1'b1});
    @(negedge PCLK);
    job_valid = 1'b0;
    chk("t5_next_setup", {PSEL, PENABLE, PADDR}, {1'b1, 1'b0, 32'h4});

    // Job 6: reset during the ACCESS phase of WR_CTRL, then a fresh job
    send_op(32'h5, 1'b1);
    n = 0;
    while (!(PSEL && PENABLE && PADDR == 32'h8) && n < 200) begin @(negedge PCLK); n++; end
    chk("t6_ctrl_wait", 128'(n < 200), 128'(1));
    PRESETn = 1'b0;
    @(negedge PCLK);
    chk("t6_reset_outputs", 128'(all_outs()), 128'(0));
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("t6_job_ready_after_reset", {job_ready, res_valid}, {1'b1, 1'b0});
    send_job(32'h3C, 1'b1);
    send_op(32'hAB, 1'b0);
    send_op(32'hFF, 1'b1);
    get_result("t6", 32'h97, 16'd2, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
